sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised single-clock FIFO, the next-generation buffer in the synchronizer/CDC library for paths where producer and consumer share one clock. Generalises the 8x8 buffer to arbitrary data width and power-of-two depth. Adds occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses and a selectable first-word-fall-through read mode. Sits between same-clock pipeline stages and feeds the dual-clock FIFO or downstream packet logic.

## Interface
- DATA_W, 8, data width in bits (>=1)
- DEPTH, 8, number of entries; power of two, >=2
- AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
- FWFT, 0, 0 = registered read mode, 1 = first-word-fall-through mode
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write request
- datain  in  DATA_W  write data
- rd_en  in  1  read request (FWFT=1: pop/acknowledge head)
- dataout  out  DATA_W  read data
- valid  out  1  dataout holds valid data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- count  out  AW+1 (AW = clog2(DEPTH))  current occupancy 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected because full
- underflow  out  1  one-cycle pulse: read rejected because empty

## Operation
- Pointers wr_ptr, rd_ptr are AW bits, wrap naturally modulo DEPTH; count tracked separately in AW+1 bits.
- Write accepted iff wr_en && !full; stores datain at wr_ptr, wr_ptr+1.
- Read accepted iff rd_en && !empty; rd_ptr+1.
- Flags evaluated from registered count at the cycle start; no same-cycle bypass: write when full is rejected even with concurrent accepted read; read when empty is rejected even with concurrent accepted write.
- count next = count + wr_acc - rd_acc; both accepted -> count unchanged.
- overflow = wr_en && full, underflow = rd_en && empty, registered, high exactly the following cycle.
- FWFT=0: on accepted read, dataout <= mem[rd_ptr], valid <= 1 next cycle; otherwise valid <= 0, dataout holds last value (never high-Z).
- FWFT=1: dataout = mem[rd_ptr] continuously, valid = !empty; rd_en with valid consumes the head, next entry visible next cycle.
- Memory contents are not reset; only control state.

## Timing
- Reset (rst high at a clock edge): pointers, count = 0; empty=1, almost_empty=1, full=0, almost_full=0; valid=0; dataout=0 (FWFT=0); overflow=underflow=0. Applies immediately mid-operation, discarding all stored data; wr_en/rd_en in the reset cycle ignored.
- Write latency: written word readable (FWFT=0 rd_en accepted / FWFT=1 valid) the cycle after the write edge; empty deasserts one cycle after first write.
- FWFT=0 read latency: 1 cycle from accepted rd_en to valid/dataout.
- full asserts the cycle after the DEPTH-th outstanding write; deasserts the cycle after a read from full.
- Threshold flags and count change on the same edge as pointers.

## Structure
- Package fifo_pkg: clog2 function, FWFT mode constants, parameter legality check (DEPTH power of two, thresholds in range) used by both FIFO generations.
- Sub-module fifo_ram: DATA_W x DEPTH register array, one synchronous write port, one asynchronous read port; FIFO control and output register in top level.

## Test plan
- DEPTH=8, FWFT=0: write 0x01..0x08 -> full=1 after 8th, count=8; 9th write 0x09 -> overflow pulse 1 cycle, count stays 8; read 8 -> dataout 0x01..0x08 in order each 1 cycle after rd_en, empty=1 at end.
- Empty FIFO: rd_en=1 -> underflow pulse, valid=0, count=0; simultaneous wr_en 0xAA + rd_en on empty -> write accepted, read rejected, count=1.
- Count=4: simultaneous write and read for 20 cycles with incrementing data -> count stays 4, pointer wrap, data order preserved.
- Full: wr_en+rd_en together -> read accepted, write rejected with overflow pulse, count=7.
- AF_THRESH=6, AE_THRESH=2: fill 0..8 -> almost_empty high for count 0..2, almost_full high for count 6..8.
- FWFT=1: write 0x11, 0x22 -> next cycle dataout=0x11 valid=1 without rd_en; rd_en -> dataout=0x22; assert rst mid-fill at count 5 -> next cycle count=0, empty=1, valid=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared definitions for the single-clock FIFO family.
//   - clog2          : constant-foldable ceiling log2, used for pointer widths
//   - FWFT_*         : read-mode selector values
//   - params_legal   : elaboration-time sanity check of a FIFO parameter set
package fifo_pkg;

  localparam int FWFT_REGISTERED  = 0;
  localparam int FWFT_FALLTHROUGH = 1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Depth must be a power of two so the pointers can wrap for free.
  function automatic bit params_legal(input int data_w, input int depth,
                                      input int af_thresh, input int ae_thresh,
                                      input int fwft);
    return (data_w >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (af_thresh >= 1) && (af_thresh <= depth) &&
           (ae_thresh >= 0) && (ae_thresh < depth) &&
           ((fwft == FWFT_REGISTERED) || (fwft == FWFT_FALLTHROUGH));
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if
//   Handshake/status bundle of sync_fifo_param.
//   master : producer/consumer side (drives wr_en, datain, rd_en)
//   slave  : the FIFO itself (drives data and all status flags)
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int CW = clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] datain;
  logic              rd_en;
  logic [DATA_W-1:0] dataout;
  logic              valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, datain, rd_en,
    input  dataout, valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, datain, rd_en,
    output dataout, valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// fifo_ram
//   DATA_W x DEPTH storage array, one synchronous write port and one
//   asynchronous (combinational) read port. Contents are never reset.
//   clk     : write clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : mem[rd_addr], combinational
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Parametrised single-clock FIFO with occupancy count, almost-full /
//   almost-empty thresholds, overflow/underflow pulses and a selectable
//   registered or first-word-fall-through read mode.
//   clk : rising-edge clock
//   rst : synchronous active-high reset of all control state
//   bus : sync_fifo_param_if.slave (wr_en/datain/rd_en in, data and flags out)
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = FWFT_REGISTERED
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave bus
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
  localparam logic [AW:0] AF_LVL   = AF_THRESH[AW:0];
  localparam logic [AW:0] AE_LVL   = AE_THRESH[AW:0];

  if (!params_legal(DATA_W, DEPTH, AF_THRESH, AE_THRESH, FWFT)) begin : g_bad_params
    $error("sync_fifo_param: illegal parameter set");
  end

  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic [AW:0]       count_next;
  logic              overflow_reg;
  logic              underflow_reg;
  logic              full;
  logic              empty;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] ram_rd_data;

  // Flags come from the registered count only: a read in the same cycle
  // does not make room for a write, and vice versa.
  assign full   = (count_reg == FULL_LVL);
  assign empty  = (count_reg == '0);
  assign wr_acc = bus.wr_en && !full && !rst;
  assign rd_acc = bus.rd_en && !empty && !rst;

  always_comb begin
    count_next = count_reg;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg     <= count_next;
      overflow_reg  <= bus.wr_en && full;
      underflow_reg <= bus.rd_en && empty;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_reg),
    .wr_data (bus.datain),
    .rd_addr (rd_ptr_reg),
    .rd_data (ram_rd_data)
  );

  if (FWFT == FWFT_FALLTHROUGH) begin : g_fwft
    // Head of the queue is always presented; rd_en just acknowledges it.
    assign bus.dataout = ram_rd_data;
    assign bus.valid   = !empty;
  end else begin : g_registered
    logic [DATA_W-1:0] dout_reg;
    logic              valid_reg;

    // dataout holds the last popped word; valid marks the cycle it arrived.
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_reg  <= '0;
        valid_reg <= 1'b0;
      end else begin
        valid_reg <= rd_acc;
        if (rd_acc) begin
          dout_reg <= ram_rd_data;
        end
      end
    end

    assign bus.dataout = dout_reg;
    assign bus.valid   = valid_reg;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_reg >= AF_LVL);
  assign bus.almost_empty = (count_reg <= AE_LVL);
  assign bus.count        = count_reg;
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param
//   Drives a registered-read instance (dut0) and a fall-through instance
//   (dut1), both DEPTH=8, AF_THRESH=6, AE_THRESH=2, against a queue model.
module tb_sync_fifo_param;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // Reference model: plain queues of stored words plus the expected
  // registered-read outputs and error pulses.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] exp_dout0;
  bit         exp_valid0;
  bit         exp_ovf0, exp_udf0, exp_ovf1, exp_udf1;

  sync_fifo_param_if #(.DATA_W(8), .DEPTH(8)) bus0 ();
  sync_fifo_param_if #(.DATA_W(8), .DEPTH(8)) bus1 ();

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0));

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive inputs, take the edge, advance the model, settle 1ns.
  task automatic cyc(input bit w0, input logic [7:0] d0, input bit r0,
                     input bit w1, input logic [7:0] d1, input bit r1);
    bit f, e;
    bus0.wr_en = w0; bus0.datain = d0; bus0.rd_en = r0;
    bus1.wr_en = w1; bus1.datain = d1; bus1.rd_en = r1;
    @(posedge clk);
    if (rst) begin
      q0.delete(); q1.delete();
      exp_dout0 = 8'h00; exp_valid0 = 0;
      exp_ovf0 = 0; exp_udf0 = 0; exp_ovf1 = 0; exp_udf1 = 0;
    end else begin
      f = (q0.size() == 8); e = (q0.size() == 0);
      exp_ovf0 = w0 && f; exp_udf0 = r0 && e;
      exp_valid0 = r0 && !e;
      if (r0 && !e) exp_dout0 = q0.pop_front();
      if (w0 && !f) q0.push_back(d0);
      f = (q1.size() == 8); e = (q1.size() == 0);
      exp_ovf1 = w1 && f; exp_udf1 = r1 && e;
      if (r1 && !e) void'(q1.pop_front());
      if (w1 && !f) q1.push_back(d1);
    end
    #1;
  endtask

  task automatic c0(input bit w, input logic [7:0] d, input bit r);
    cyc(w, d, r, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic c1(input bit w, input logic [7:0] d, input bit r);
    cyc(1'b0, 8'h00, 1'b0, w, d, r);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(1'b1, 8'h55, 1'b1, 1'b1, 8'h66, 1'b1);
    cyc(1'b1, 8'h57, 1'b1, 1'b1, 8'h67, 1'b1);
    rst = 1'b0;
    total++; if (bus0.count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus0.count); end
    total++; if (bus0.empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", bus0.empty); end
    total++; if (bus0.full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", bus0.full); end
    total++; if (bus0.almost_empty !== 1'b1) begin bad++; $display("FAIL reset_ae: got %b want 1", bus0.almost_empty); end
    total++; if (bus0.almost_full !== 1'b0) begin bad++; $display("FAIL reset_af: got %b want 0", bus0.almost_full); end
    total++; if (bus0.valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus0.valid); end
    total++; if (bus0.dataout !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", bus0.dataout); end
    total++; if ({bus0.overflow, bus0.underflow} !== 2'b00) begin bad++; $display("FAIL reset_err: got %b want 00", {bus0.overflow, bus0.underflow}); end
    total++; if ({bus1.count, bus1.empty, bus1.valid} !== {4'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL reset_fwft: got cnt=%0d empty=%b valid=%b want 0 1 0", bus1.count, bus1.empty, bus1.valid); end
    $display("reset: count=%0d empty=%b", bus0.count, bus0.empty);
  endtask

  task automatic test_fill_overflow;
    for (int i = 1; i <= 8; i++) begin
      c0(1'b1, 8'(i), 1'b0);
      total++; if (bus0.count !== 4'(i)) begin bad++; $display("FAIL fill_count: got %0d want %0d", bus0.count, i); end
      total++; if (bus0.full !== (i == 8)) begin bad++; $display("FAIL fill_full: got %b want %b at count %0d", bus0.full, (i == 8), i); end
      $display("write %02h: count=%0d full=%b", i, bus0.count, bus0.full);
    end
    c0(1'b1, 8'h09, 1'b0);
    total++; if (bus0.overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse: got %b want 1", bus0.overflow); end
    total++; if (bus0.count !== 4'd8) begin bad++; $display("FAIL ovf_count: got %0d want 8", bus0.count); end
    c0(1'b0, 8'h00, 1'b0);
    total++; if (bus0.overflow !== 1'b0) begin bad++; $display("FAIL ovf_single: got %b want 0", bus0.overflow); end
    for (int i = 1; i <= 8; i++) begin
      c0(1'b0, 8'h00, 1'b1);
      total++; if (bus0.valid !== 1'b1) begin bad++; $display("FAIL drain_valid: got %b want 1", bus0.valid); end
      total++; if (bus0.dataout !== 8'(i)) begin bad++; $display("FAIL drain_data: got %h want %h", bus0.dataout, 8'(i)); end
      $display("read: dataout=%02h count=%0d", bus0.dataout, bus0.count);
    end
    total++; if (bus0.empty !== 1'b1) begin bad++; $display("FAIL drain_empty: got %b want 1", bus0.empty); end
  endtask

  task automatic test_underflow;
    c0(1'b0, 8'h00, 1'b1);
    total++; if (bus0.underflow !== 1'b1) begin bad++; $display("FAIL udf_pulse: got %b want 1", bus0.underflow); end
    total++; if (bus0.valid !== 1'b0) begin bad++; $display("FAIL udf_valid: got %b want 0", bus0.valid); end
    total++; if (bus0.count !== 4'd0) begin bad++; $display("FAIL udf_count: got %0d want 0", bus0.count); end
    c0(1'b1, 8'hAA, 1'b1);
    total++; if (bus0.count !== 4'd1) begin bad++; $display("FAIL udf_wr_count: got %0d want 1", bus0.count); end
    total++; if ({bus0.underflow, bus0.valid} !== 2'b10) begin bad++; $display("FAIL udf_wr_flags: got %b want 10", {bus0.underflow, bus0.valid}); end
    c0(1'b0, 8'h00, 1'b1);
    total++; if ({bus0.valid, bus0.dataout, bus0.underflow} !== {1'b1, 8'hAA, 1'b0}) begin bad++; $display("FAIL udf_readback: got v=%b d=%h u=%b want 1 aa 0", bus0.valid, bus0.dataout, bus0.underflow); end
    $display("underflow: read back %02h empty=%b", bus0.dataout, bus0.empty);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) c0(1'b1, 8'h40 + 8'(i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      logic [7:0] want;
      want = (i < 4) ? 8'h40 + 8'(i) : 8'h80 + 8'(i - 4);
      c0(1'b1, 8'h80 + 8'(i), 1'b1);
      total++; if (bus0.count !== 4'd4) begin bad++; $display("FAIL b2b_count: got %0d want 4", bus0.count); end
      total++; if ({bus0.valid, bus0.dataout} !== {1'b1, want}) begin bad++; $display("FAIL b2b_data: got v=%b d=%h want 1 %h", bus0.valid, bus0.dataout, want); end
      $display("b2b %0d: dataout=%02h count=%0d", i, bus0.dataout, bus0.count);
    end
    for (int i = 0; i < 4; i++) begin
      c0(1'b0, 8'h00, 1'b1);
      total++; if (bus0.dataout !== 8'h90 + 8'(i)) begin bad++; $display("FAIL b2b_tail: got %h want %h", bus0.dataout, 8'h90 + 8'(i)); end
    end
  endtask

  task automatic test_full_rw;
    for (int i = 0; i < 8; i++) c0(1'b1, 8'h60 + 8'(i), 1'b0);
    c0(1'b1, 8'hEE, 1'b1);
    total++; if (bus0.count !== 4'd7) begin bad++; $display("FAIL fullrw_count: got %0d want 7", bus0.count); end
    total++; if (bus0.overflow !== 1'b1) begin bad++; $display("FAIL fullrw_ovf: got %b want 1", bus0.overflow); end
    total++; if ({bus0.valid, bus0.dataout} !== {1'b1, 8'h60}) begin bad++; $display("FAIL fullrw_data: got v=%b d=%h want 1 60", bus0.valid, bus0.dataout); end
    $display("full rw: count=%0d overflow=%b", bus0.count, bus0.overflow);
    for (int i = 1; i < 8; i++) begin
      c0(1'b0, 8'h00, 1'b1);
      total++; if (bus0.dataout !== 8'h60 + 8'(i)) begin bad++; $display("FAIL fullrw_drain: got %h want %h", bus0.dataout, 8'h60 + 8'(i)); end
    end
  endtask

  task automatic test_thresholds;
    for (int n = 0; n <= 8; n++) begin
      if (n > 0) c0(1'b1, 8'(n), 1'b0);
      total++; if (bus0.almost_empty !== (n <= 2)) begin bad++; $display("FAIL thr_ae: got %b want %b count %0d", bus0.almost_empty, (n <= 2), n); end
      total++; if (bus0.almost_full !== (n >= 6)) begin bad++; $display("FAIL thr_af: got %b want %b count %0d", bus0.almost_full, (n >= 6), n); end
      $display("thresh count=%0d ae=%b af=%b", bus0.count, bus0.almost_empty, bus0.almost_full);
    end
    for (int n = 7; n >= 0; n--) begin
      c0(1'b0, 8'h00, 1'b1);
      total++; if ({bus0.almost_empty, bus0.almost_full} !== {(n <= 2), (n >= 6)}) begin bad++; $display("FAIL thr_drain: got ae/af %b want %b count %0d", {bus0.almost_empty, bus0.almost_full}, {(n <= 2), (n >= 6)}, n); end
    end
  endtask

  task automatic test_fwft;
    rst = 1'b1; c1(1'b0, 8'h00, 1'b0); rst = 1'b0;
    c1(1'b1, 8'h11, 1'b0);
    total++; if ({bus1.valid, bus1.dataout} !== {1'b1, 8'h11}) begin bad++; $display("FAIL fwft_first: got v=%b d=%h want 1 11", bus1.valid, bus1.dataout); end
    c1(1'b1, 8'h22, 1'b0);
    total++; if ({bus1.valid, bus1.dataout, bus1.count} !== {1'b1, 8'h11, 4'd2}) begin bad++; $display("FAIL fwft_hold: got v=%b d=%h c=%0d want 1 11 2", bus1.valid, bus1.dataout, bus1.count); end
    c1(1'b0, 8'h00, 1'b1);
    total++; if ({bus1.valid, bus1.dataout, bus1.count} !== {1'b1, 8'h22, 4'd1}) begin bad++; $display("FAIL fwft_pop: got v=%b d=%h c=%0d want 1 22 1", bus1.valid, bus1.dataout, bus1.count); end
    c1(1'b0, 8'h00, 1'b1);
    total++; if ({bus1.valid, bus1.empty} !== 2'b01) begin bad++; $display("FAIL fwft_empty: got v/e %b want 01", {bus1.valid, bus1.empty}); end
    for (int i = 0; i < 5; i++) c1(1'b1, 8'hC0 + 8'(i), 1'b0);
    total++; if (bus1.count !== 4'd5) begin bad++; $display("FAIL fwft_fill: got %0d want 5", bus1.count); end
    rst = 1'b1; c1(1'b1, 8'hFF, 1'b0); rst = 1'b0;
    total++; if ({bus1.count, bus1.empty, bus1.valid} !== {4'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL fwft_midrst: got c=%0d e=%b v=%b want 0 1 0", bus1.count, bus1.empty, bus1.valid); end
    $display("fwft mid-reset: count=%0d empty=%b valid=%b", bus1.count, bus1.empty, bus1.valid);
  endtask

  task automatic test_random;
    for (int j = 0; j < 600; j++) begin
      int wp;
      bit w0, r0, w1, r1;
      wp = ((j / 100) % 2 == 0) ? 75 : 30;
      w0 = ($urandom_range(0, 99) < wp); r0 = ($urandom_range(0, 99) < 55);
      w1 = ($urandom_range(0, 99) < wp); r1 = ($urandom_range(0, 99) < 55);
      rst = ($urandom_range(0, 149) == 0);
      cyc(w0, 8'($urandom), r0, w1, 8'($urandom), r1);
      rst = 1'b0;
      total++; if (bus0.count !== 4'(q0.size())) begin bad++; $display("FAIL rnd0_count: got %0d want %0d", bus0.count, q0.size()); end
      total++; if ({bus0.full, bus0.empty} !== {q0.size() == 8, q0.size() == 0}) begin bad++; $display("FAIL rnd0_flags: got f/e %b want %b", {bus0.full, bus0.empty}, {q0.size() == 8, q0.size() == 0}); end
      total++; if ({bus0.almost_full, bus0.almost_empty} !== {q0.size() >= 6, q0.size() <= 2}) begin bad++; $display("FAIL rnd0_thr: got af/ae %b want %b", {bus0.almost_full, bus0.almost_empty}, {q0.size() >= 6, q0.size() <= 2}); end
      total++; if ({bus0.valid, bus0.dataout} !== {exp_valid0, exp_dout0}) begin bad++; $display("FAIL rnd0_data: got v=%b d=%h want %b %h", bus0.valid, bus0.dataout, exp_valid0, exp_dout0); end
      total++; if ({bus0.overflow, bus0.underflow} !== {exp_ovf0, exp_udf0}) begin bad++; $display("FAIL rnd0_err: got o/u %b want %b", {bus0.overflow, bus0.underflow}, {exp_ovf0, exp_udf0}); end
      total++; if (bus1.count !== 4'(q1.size())) begin bad++; $display("FAIL rnd1_count: got %0d want %0d", bus1.count, q1.size()); end
      total++; if (bus1.valid !== (q1.size() != 0)) begin bad++; $display("FAIL rnd1_valid: got %b want %b", bus1.valid, (q1.size() != 0)); end
      if (q1.size() != 0) begin
        total++; if (bus1.dataout !== q1[0]) begin bad++; $display("FAIL rnd1_head: got %h want %h", bus1.dataout, q1[0]); end
      end
      total++; if ({bus1.overflow, bus1.underflow} !== {exp_ovf1, exp_udf1}) begin bad++; $display("FAIL rnd1_err: got o/u %b want %b", {bus1.overflow, bus1.underflow}, {exp_ovf1, exp_udf1}); end
      $display("rnd %0d: w0=%b r0=%b cnt0=%0d v0=%b d0=%02h | w1=%b r1=%b cnt1=%0d d1=%02h",
               j, w0, r0, bus0.count, bus0.valid, bus0.dataout, w1, r1, bus1.count, bus1.dataout);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    bus0.wr_en = 1'b0; bus0.datain = '0; bus0.rd_en = 1'b0;
    bus1.wr_en = 1'b0; bus1.datain = '0; bus1.rd_en = 1'b0;
    test_reset();
    test_fill_overflow();
    test_underflow();
    test_back_to_back();
    test_full_rw();
    test_thresholds();
    test_fwft();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
